// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V core front end.
//   XLEN      : datapath / address width
//   RESET_PC  : default program counter after reset
//   ILEN      : instruction word width
//   INSTR_NOP : canonical NOP encoding (addi x0, x0, 0)
package riscv_pkg;
  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam int              ILEN      = 32;
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-fetch bus bundle: imem request/response, redirect and the
// decode-side valid/ready handshake.
//   master : the fetch stage (drives imem request and decode outputs)
//   slave  : the environment (memory, branch unit and decode)
interface fetch_stage_if import riscv_pkg::*; #(
  parameter int XLEN = riscv_pkg::XLEN
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [ILEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req_valid, imem_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous show-ahead FIFO holding fetched {pc, instr} entries.
//   clk, rst     : clock, synchronous active-high reset
//   flush_i      : drop all entries (takes priority over push/pop)
//   push_i       : write push_data_i at the tail
//   pop_i        : retire the head entry
//   empty_o      : no entries
//   count_o      : current occupancy (0..DEPTH)
//   head_o       : head entry, valid whenever !empty_o
// DEPTH must be a power of two so the pointers wrap for free. The caller
// guarantees no push when full without a pop, and no pop when empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [WIDTH-1:0]       head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues word reads to imem,
// buffers returned instructions with their PC and hands them to decode.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_stage_if.master
//              imem_req_valid/ready, imem_addr      request channel
//              imem_rsp_valid, imem_rsp_data        in-order response
//              redirect_valid, redirect_pc          flush + restart
//              id_valid/ready, id_instr, id_pc      decode handshake
// Flow control: a request is only issued while buffered entries plus
// in-flight requests stay below FIFO_DEPTH, so every response has a slot.
module fetch_stage import riscv_pkg::*; #(
  parameter int              XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int              EW         = XLEN + ILEN;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [CW:0]     CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d;     // requests issued, response not yet seen
  logic [CW-1:0]   drop_q, drop_d;   // in-flight responses to discard
  logic [CW-1:0]   fifo_cnt;
  logic [CW:0]     credits;
  logic [XLEN-1:0] redir_pc;
  logic            redirect, issue, rsp, push, pop;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_head;

  assign redirect = bus.redirect_valid;
  assign rsp      = bus.imem_rsp_valid;
  assign redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

  always_comb begin
    credits            = {1'b0, fifo_cnt} + {1'b0, out_q};
    bus.imem_req_valid = !rst && !redirect && (credits < CREDIT_MAX);
    issue              = bus.imem_req_valid && bus.imem_req_ready;
    push               = rsp && (drop_q == '0) && !redirect;
    pop                = !fifo_empty && bus.id_ready && !redirect;
  end

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q + CW'(issue) - CW'(rsp);
    drop_d   = drop_q;
    if (redirect) begin
      pc_d     = redir_pc;
      rsp_pc_d = redir_pc;
      // out_q already counts requests marked for discard, so every request
      // still in flight after this cycle is to be dropped.
      drop_d   = out_q - CW'(rsp);
    end else begin
      if (issue) pc_d = pc_q + PC_STEP;
      if (push)  rsp_pc_d = rsp_pc_q + PC_STEP;
      if (rsp && drop_q != '0) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i ({rsp_pc_q, bus.imem_rsp_data}),
    .pop_i       (pop),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt),
    .head_o      (fifo_head)
  );

  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = !fifo_empty;
  // Zero the payload while empty so stale storage never reaches decode.
  assign bus.id_instr  = fifo_empty ? '0 : fifo_head[ILEN-1:0];
  assign bus.id_pc     = fifo_empty ? '0 : fifo_head[EW-1:ILEN];
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import riscv_pkg::*;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(32)) bus();
  fetch_stage_if #(.XLEN(32)) bw();

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst(rst), .bus(bw));

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: after reset or a redirect to T, decode must see T, T+4, ...
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t exp_q[$];

  task automatic start_epoch(input logic [31:0] pc);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 128; i++) begin
      e.pc    = pc + 32'(4 * i);
      e.instr = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- memory model (main DUT): in order, latency lat_min..lat_max
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  int          cyc = 0;
  int          last_due = 0;
  int          outst = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] issued[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mem_obs
    pend_t p;
    int    d;
    if (rst) begin
      pend.delete();
      outst    = 0;
      last_due = 0;
      exp_addr = 32'h0;
    end else begin
      if (bus.imem_rsp_valid) outst--;
      if (bus.redirect_valid)
        chk(!bus.imem_req_valid, "no_issue_on_redirect", 32'(bus.imem_req_valid), 32'h0);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk(bus.imem_addr == exp_addr, "issue_addr", bus.imem_addr, exp_addr);
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        p.addr = bus.imem_addr;
        p.due  = d;
        pend.push_back(p);
        last_due = d;
        outst++;
        issued.push_back(bus.imem_addr);
        exp_addr = exp_addr + 32'd4;
      end
      if (bus.redirect_valid) exp_addr = {bus.redirect_pc[31:2], 2'b00};
      chk(outst <= DEPTH, "outstanding_bound", 32'(outst), 32'(DEPTH));
    end
  end

  initial begin : mem_drv
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      tick();
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
      end
    end
  end

  // ---------------- scoreboard monitor
  int          delivered = 0;
  bit          hold_q = 1'b0;
  logic [31:0] hold_pc, hold_instr;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q)
        chk(bus.id_valid && bus.id_pc == hold_pc && bus.id_instr == hold_instr,
            "id_stable", bus.id_pc, hold_pc);
      if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_instr", bus.id_pc, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk(bus.id_pc == e.pc, "id_pc", bus.id_pc, e.pc);
          chk(bus.id_instr == e.instr, "id_instr", bus.id_instr, e.instr);
          delivered++;
        end
      end
      hold_q     = bus.id_valid && !bus.id_ready && !bus.redirect_valid;
      hold_pc    = bus.id_pc;
      hold_instr = bus.id_instr;
    end
  end

  // ---------------- wrap-around instance: 1-cycle memory, always ready
  logic        pend_w = 1'b0;
  logic [31:0] pend_w_addr = 32'h0;
  logic [31:0] issued_w[$];

  always @(negedge clk) begin
    if (rst) begin
      pend_w = 1'b0;
      issued_w.delete();
    end else begin
      pend_w = bw.imem_req_valid && bw.imem_req_ready;
      if (pend_w) begin
        pend_w_addr = bw.imem_addr;
        issued_w.push_back(bw.imem_addr);
      end
    end
  end

  initial begin : mem_w_drv
    bw.imem_req_ready  = 1'b1;
    bw.id_ready        = 1'b1;
    bw.redirect_valid  = 1'b0;
    bw.redirect_pc     = 32'h0;
    bw.imem_rsp_valid  = 1'b0;
    bw.imem_rsp_data   = 32'h0;
    forever begin
      tick();
      bw.imem_rsp_valid = pend_w;
      bw.imem_rsp_data  = mem_word(pend_w_addr);
    end
  end

  // ---------------- stimulus
  task automatic do_reset();
    tick();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    start_epoch(32'h0);
    tick();
    rst = 1'b0;
  endtask

  initial begin : stim
    int          d0, age;
    bit          prev_redir;
    logic [31:0] tgt;
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;
    start_epoch(32'h0);
    tick();
    @(negedge clk);
    chk(!bus.imem_req_valid, "rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk(!bus.id_valid, "rst_id_valid", 32'(bus.id_valid), 32'h0);
    chk(bus.id_instr == 32'h0, "rst_id_instr", bus.id_instr, 32'h0);
    chk(bus.id_pc == 32'h0, "rst_id_pc", bus.id_pc, 32'h0);

    // 1: streaming from reset, 1-cycle memory
    tick();
    rst = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b1;
    @(negedge clk);
    chk(bus.imem_req_valid && bus.imem_addr == 32'h0, "first_issue", bus.imem_addr, 32'h0);
    tick();
    @(negedge clk);
    chk(!bus.id_valid, "id_valid_c1", 32'(bus.id_valid), 32'h0);
    tick();
    @(negedge clk);
    chk(bus.id_valid && bus.id_pc == 32'h0, "id_valid_c2", bus.id_pc, 32'h0);
    repeat (6) tick();
    chk(delivered >= 4, "t1_delivered", 32'(delivered), 32'd4);
    // 5: wrap-around instance ran alongside
    chk(issued_w.size() >= 3, "wrap_issue_cnt", 32'(issued_w.size()), 32'd3);
    if (issued_w.size() >= 3) begin
      chk(issued_w[0] == 32'hFFFF_FFF8, "wrap_addr0", issued_w[0], 32'hFFFF_FFF8);
      chk(issued_w[1] == 32'hFFFF_FFFC, "wrap_addr1", issued_w[1], 32'hFFFF_FFFC);
      chk(issued_w[2] == 32'h0000_0000, "wrap_addr2", issued_w[2], 32'h0000_0000);
    end

    // 2: decode stalled for 5 cycles
    do_reset();
    bus.id_ready = 1'b0;
    issued.delete();
    repeat (5) tick();
    chk(issued.size() == 2, "stall_issue_cnt", 32'(issued.size()), 32'd2);
    @(negedge clk);
    chk(!bus.imem_req_valid, "stall_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk(bus.id_valid && bus.id_pc == 32'h0, "stall_id_pc", bus.id_pc, 32'h0);
    tick();
    d0 = delivered;
    bus.id_ready = 1'b1;
    repeat (6) tick();
    chk(delivered - d0 >= 3, "stall_resume", 32'(delivered - d0), 32'd3);

    // 3: redirect with two requests in flight (latency 3)
    lat_min = 3;
    lat_max = 3;
    do_reset();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    start_epoch(32'h0000_0100);
    issued.delete();
    d0 = delivered;
    @(negedge clk);
    chk(outst == 2, "t3_inflight", 32'(outst), 32'd2);
    tick();
    bus.redirect_valid = 1'b0;
    repeat (10) tick();
    chk(issued.size() > 0 && issued[0] == 32'h0000_0100, "t3_next_addr",
        issued.size() > 0 ? issued[0] : 32'hDEAD_BEEF, 32'h0000_0100);
    chk(delivered > d0, "t3_delivered", 32'(delivered - d0), 32'd1);

    // 4: redirect coinciding with a response and a decode handshake
    lat_min = 1;
    lat_max = 1;
    do_reset();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    start_epoch(32'h0000_0200);
    d0 = delivered;
    @(negedge clk);
    chk(bus.id_valid && bus.imem_rsp_valid && bus.id_ready, "t4_collision",
        {29'h0, bus.id_valid, bus.imem_rsp_valid, bus.id_ready}, 32'h7);
    tick();
    bus.redirect_valid = 1'b0;
    repeat (8) tick();
    chk(delivered > d0, "t4_delivered", 32'(delivered - d0), 32'd1);

    // 6: random traffic, latency 1-3, redirects and occasional reset
    lat_min = 1;
    lat_max = 3;
    do_reset();
    d0 = delivered;
    age = 0;
    prev_redir = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      rst = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.imem_req_ready = ($urandom_range(3, 0) != 0);
      bus.id_ready       = ($urandom_range(2, 0) != 0);
      tgt = $urandom;
      bus.redirect_pc = tgt;
      if ($urandom_range(199, 0) == 0) begin
        rst = 1'b1;
        start_epoch(32'h0);
        age = 0;
        prev_redir = 1'b0;
      end else if (age > 60 || (prev_redir && $urandom_range(1, 0) == 1) ||
                   $urandom_range(24, 0) == 0) begin
        bus.redirect_valid = 1'b1;
        start_epoch({tgt[31:2], 2'b00});
        age = 0;
        prev_redir = 1'b1;
      end else begin
        age++;
        prev_redir = 1'b0;
      end
    end
    tick();
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b1;
    repeat (20) tick();
    chk(delivered - d0 > 40, "t6_delivered", 32'(delivered - d0), 32'd41);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
